merge_skid_buffer: RTL and testbench

MERGE_SKID_BUFFER -- requirements
Module: merge_skid_buffer

---
 rtl/merge_skid_buffer.sv | 92 +++++++++
 tb/tb_merge_skid_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_skid_buffer.sv
// Two-entry skid FIFO that stores a field-merge of old_data and new_data.
// Ports: clk, rst (sync, active-high), flush; sel, old_data, new_data and
// in_valid/in_ready for input; out_valid/out_ready/out_data for output;
// count (0..2) shows the entries held; sel_err is sticky and sets when an
// out-of-range sel was pushed.
module merge_skid_buffer #(
    parameter int WIDTH = 32,
    parameter int NSEL  = 4,
    parameter logic [NSEL-1:0][WIDTH-1:0] MASKS = '0,
    localparam int SW = (NSEL > 1) ? $clog2(NSEL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [SW-1:0]    sel,
    input  logic [WIDTH-1:0] old_data,
    input  logic [WIDTH-1:0] new_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count,
    output logic             sel_err
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] merged;
    logic             sel_ok;
    logic             push;
    logic             pop;

    // An out-of-range sel matches no entry, so the mask stays zero and
    // old_data passes through unchanged.
    always_comb begin
        mask   = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NSEL; i++) begin
            if (sel == SW'(i)) begin
                mask   = MASKS[i];
                sel_ok = 1'b1;
            end
        end
    end

    assign merged = (old_data & ~mask) | (new_data & mask);

    // Handshake signals come only from registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            sel_err <= 1'b0;
        end else begin
            if (push && !sel_ok)
                sel_err <= 1'b1;
            if (flush) begin
                count <= 2'd0;
            end else begin
                unique case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0)
                            head <= merged;
                        else
                            tail <= merged;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    // Only reachable with count==1: head leaves as the
                    // new entry replaces it.
                    2'b11: head <= merged;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_merge_skid_buffer.sv
// Scoreboard bench for merge_skid_buffer (WIDTH=8, NSEL=3).
// Accepted pushes queue their expected value; a monitor checks every pop.
module tb_merge_skid_buffer;

    localparam int W = 8;
    localparam logic [2:0][7:0] M = {8'hFF, 8'hF0, 8'h00};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] old_data = 8'h00;
    logic [7:0] new_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] count;
    logic       sel_err;

    logic [7:0] exp_in = 8'h00;
    logic [7:0] expq[$];
    int checks = 0;
    int errors = 0;
    int pops_seen = 0;

    merge_skid_buffer #(
        .WIDTH(W),
        .NSEL(3),
        .MASKS(M)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .sel(sel),
        .old_data(old_data),
        .new_data(new_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Stimulus side of the scoreboard: record accepted pushes.
    always @(negedge clk) begin
        if (rst || flush)
            expq.delete();
        else if (in_valid && in_ready)
            expq.push_back(exp_in);
    end

    // Monitor: every pop must match the oldest queued value.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            pops_seen++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL pop_empty got %h, none expected", out_data);
            end else begin
                e = expq.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data got %h want %h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] o,
                         input logic [7:0] n, input logic [7:0] e);
        sel      = s;
        old_data = o;
        new_data = n;
        exp_in   = e;
        in_valid = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] sv [3];
        logic [7:0] ev [3];
        sv = '{2'd1, 2'd0, 2'd2};
        ev = '{8'h5B, 8'hAB, 8'h5C};

        step();
        step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sel_err", 32'(sel_err), 0);
        chk("rst_head", 32'(out_data), 0);

        // Merge modes
        for (int i = 0; i < 3; i++) begin
            drive(sv[i], 8'hAB, 8'h5C, ev[i]);
            step();
            in_valid = 1'b0;
            chk("merge_count", 32'(count), 1);
            chk("merge_valid", 32'(out_valid), 1);
            chk("merge_data", 32'(out_data), 32'(ev[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("merge_drain", 32'(count), 0);
        end
        chk("merge_sel_err", 32'(sel_err), 0);

        // Backpressure
        drive(2'd2, 8'h00, 8'h11, 8'h11);
        step();
        drive(2'd2, 8'h00, 8'h22, 8'h22);
        step();
        drive(2'd2, 8'h00, 8'h33, 8'h33);
        chk("bp_in_ready", 32'(in_ready), 0);
        step();
        in_valid = 1'b0;
        chk("bp_count", 32'(count), 2);
        chk("bp_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        chk("bp_ready_after_pop", 32'(in_ready), 1);
        chk("bp_count_1", 32'(count), 1);
        chk("bp_head_2", 32'(out_data), 32'h22);
        step();
        out_ready = 1'b0;
        chk("bp_empty", 32'(count), 0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(2'd2, 8'h00, 8'(i), 8'(i));
            step();
            chk("stream_count", 32'(count), 1);
            chk("stream_data", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream_empty", 32'(count), 0);

        // Flush with count=2 and with count=1
        drive(2'd2, 8'h00, 8'hAA, 8'hAA);
        step();
        drive(2'd2, 8'h00, 8'hBB, 8'hBB);
        step();
        chk("flush_pre", 32'(count), 2);
        drive(2'd2, 8'h00, 8'h77, 8'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        drive(2'd2, 8'h00, 8'hAA, 8'hAA);
        step();
        drive(2'd2, 8'h00, 8'h77, 8'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_count", 32'(count), 0);

        // Bad sel
        drive(2'd3, 8'hC3, 8'h5C, 8'hC3);
        step();
        in_valid = 1'b0;
        chk("badsel_data", 32'(out_data), 32'hC3);
        chk("badsel_err", 32'(sel_err), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("badsel_err_flush", 32'(sel_err), 1);

        // Reset mid-stream
        drive(2'd2, 8'h00, 8'h01, 8'h01);
        step();
        drive(2'd2, 8'h00, 8'h02, 8'h02);
        step();
        in_valid = 1'b0;
        chk("rst2_pre", 32'(count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_valid", 32'(out_valid), 0);
        chk("rst2_ready", 32'(in_ready), 1);
        chk("rst2_sel_err", 32'(sel_err), 0);
        drive(2'd2, 8'h00, 8'h9E, 8'h9E);
        step();
        in_valid = 1'b0;
        chk("rst2_valid_after", 32'(out_valid), 1);
        chk("rst2_data", 32'(out_data), 32'h9E);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();

        chk("total_pops", 32'(pops_seen), 13);
        chk("queue_left", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
